// File: rtl/usb_rx_fsm.sv
// USB full-speed packet receive controller.
//
// Takes destuffed bytes from the RX shift register, checks SYNC and PID, and
// streams DATA payload into the RX buffer. A two-byte hold pipeline keeps the
// trailing CRC16 bytes out of the buffer.
//
// Build option: define RX_TIMEOUT_EN to abort a packet when no byte strobe
// arrives within TIMEOUT_CYCLES clocks.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   d_edge            start of bus activity
//   byte_ready        one-cycle strobe, rx_byte valid
//   rx_byte[7:0]      received byte
//   eop               one-cycle end-of-packet strobe
//   crc_ok            CRC16 residue good (sampled with eop)
//   crc_clear         pulse: clear the CRC16 checker
//   crc_enable        CRC16 checker accumulates the current byte
//   store_rx_data     pulse: write rx_data into the RX buffer
//   rx_data[7:0]      payload byte to the buffer
//   rx_packet[1:0]    00 none, 01 DATA, 10 ACK, 11 NAK
//   rx_data_size[6:0] payload byte count of the last good DATA packet
//   rx_data_ready     pulse: good packet complete
//   rx_error          sticky malformed-packet flag
//   rcving            reception in progress
module usb_rx_fsm #(
  parameter int unsigned MAX_DATA       = 64,
  parameter int unsigned TIMEOUT_CYCLES = 800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       byte_ready,
  input  logic [7:0] rx_byte,
  input  logic       eop,
  input  logic       crc_ok,
  output logic       crc_clear,
  output logic       crc_enable,
  output logic       store_rx_data,
  output logic [7:0] rx_data,
  output logic [1:0] rx_packet,
  output logic [6:0] rx_data_size,
  output logic       rx_data_ready,
  output logic       rx_error,
  output logic       rcving
);

  typedef enum logic [2:0] {
    StIdle, StRcvSync, StRcvPid, StWaitEop, StRcvData, StDone, StErr
  } state_e;

  // Byte count at which one more byte means payload + CRC exceeds MAX_DATA + 2.
  localparam logic [7:0] OvfCnt = 8'(MAX_DATA + 2);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  hold0_q, hold0_d;  // newest byte
  logic [7:0]  hold1_q, hold1_d;  // oldest byte
  logic [1:0]  pkt_type_q, pkt_type_d;
  logic        crc_clear_q, crc_clear_d;
  logic        crc_enable_q, crc_enable_d;
  logic        store_q, store_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [1:0]  rx_packet_q, rx_packet_d;
  logic [6:0]  rx_data_size_q, rx_data_size_d;
  logic        rx_data_ready_q, rx_data_ready_d;
  logic        rx_error_q, rx_error_d;
  logic        rcving_q, rcving_d;
  logic [7:0]  size_full;
  logic        abort_idle;
  logic        receiving;
  logic        tmo_hit;

  assign receiving = (state_q == StRcvSync) || (state_q == StRcvPid) ||
                     (state_q == StWaitEop) || (state_q == StRcvData);
  assign size_full = cnt_q - 8'd2;

`ifdef RX_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = 16'd0;
    if (receiving && !byte_ready) tmo_d = tmo_q + 16'd1;
  end

  assign tmo_hit = receiving && !byte_ready && !eop &&
                   (tmo_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= 16'd0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    hold0_d         = hold0_q;
    hold1_d         = hold1_q;
    pkt_type_d      = pkt_type_q;
    crc_clear_d     = 1'b0;
    crc_enable_d    = 1'b0;
    store_d         = 1'b0;
    rx_data_d       = rx_data_q;
    rx_packet_d     = rx_packet_q;
    rx_data_size_d  = rx_data_size_q;
    rx_data_ready_d = 1'b0;
    rx_error_d      = rx_error_q;
    rcving_d        = rcving_q;
    // Errors seen on eop end the packet outright: the bus is already idle, so
    // waiting in StErr for another eop would hang.
    abort_idle      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (d_edge) begin
          state_d     = StRcvSync;
          crc_clear_d = 1'b1;
          rcving_d    = 1'b1;
          rx_error_d  = 1'b0;
          rx_packet_d = 2'b00;
          cnt_d       = 8'd0;
          pkt_type_d  = 2'b00;
        end
      end
      StRcvSync: begin
        if (eop) begin
          abort_idle = 1'b1;
        end else if (byte_ready) begin
          state_d = (rx_byte == 8'h80) ? StRcvPid : StErr;
        end
      end
      StRcvPid: begin
        if (eop) begin
          abort_idle = 1'b1;
        end else if (byte_ready) begin
          case (rx_byte)
            8'hC3: begin state_d = StRcvData; pkt_type_d = 2'b01; end
            8'hB4: begin state_d = StWaitEop; pkt_type_d = 2'b10; end
            8'hA5: begin state_d = StWaitEop; pkt_type_d = 2'b11; end
            default: state_d = StErr;
          endcase
        end
      end
      StWaitEop: begin
        if (eop && byte_ready) begin
          abort_idle = 1'b1;
        end else if (eop) begin
          state_d = StDone;
        end else if (byte_ready) begin
          state_d = StErr;
        end
      end
      StRcvData: begin
        if (eop && byte_ready) begin
          abort_idle = 1'b1;
        end else if (eop) begin
          if (cnt_q >= 8'd2 && crc_ok) begin
            rx_data_size_d = size_full[6:0];
            state_d        = StDone;
          end else begin
            abort_idle = 1'b1;
          end
        end else if (byte_ready) begin
          if (cnt_q == OvfCnt) begin
            state_d = StErr;
          end else begin
            crc_enable_d = 1'b1;
            if (cnt_q >= 8'd2) begin
              store_d   = 1'b1;
              rx_data_d = hold1_q;
            end
            hold1_d = hold0_q;
            hold0_d = rx_byte;
            cnt_d   = cnt_q + 8'd1;
          end
        end
      end
      StDone: begin
        rx_packet_d     = pkt_type_q;
        rx_data_ready_d = 1'b1;
        rcving_d        = 1'b0;
        state_d         = StIdle;
      end
      StErr: begin
        if (eop) begin
          state_d  = StIdle;
          rcving_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (tmo_hit) abort_idle = 1'b1;

    if (abort_idle) begin
      state_d  = StIdle;
      rcving_d = 1'b0;
    end
    if (abort_idle || (state_d == StErr)) rx_error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= 8'd0;
      hold0_q         <= 8'd0;
      hold1_q         <= 8'd0;
      pkt_type_q      <= 2'b00;
      crc_clear_q     <= 1'b0;
      crc_enable_q    <= 1'b0;
      store_q         <= 1'b0;
      rx_data_q       <= 8'd0;
      rx_packet_q     <= 2'b00;
      rx_data_size_q  <= 7'd0;
      rx_data_ready_q <= 1'b0;
      rx_error_q      <= 1'b0;
      rcving_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      hold0_q         <= hold0_d;
      hold1_q         <= hold1_d;
      pkt_type_q      <= pkt_type_d;
      crc_clear_q     <= crc_clear_d;
      crc_enable_q    <= crc_enable_d;
      store_q         <= store_d;
      rx_data_q       <= rx_data_d;
      rx_packet_q     <= rx_packet_d;
      rx_data_size_q  <= rx_data_size_d;
      rx_data_ready_q <= rx_data_ready_d;
      rx_error_q      <= rx_error_d;
      rcving_q        <= rcving_d;
    end
  end

  assign crc_clear     = crc_clear_q;
  assign crc_enable    = crc_enable_q;
  assign store_rx_data = store_q;
  assign rx_data       = rx_data_q;
  assign rx_packet     = rx_packet_q;
  assign rx_data_size  = rx_data_size_q;
  assign rx_data_ready = rx_data_ready_q;
  assign rx_error      = rx_error_q;
  assign rcving        = rcving_q;

endmodule

// File: tb/tb_usb_rx_fsm.sv
// Directed bench for usb_rx_fsm: handshake, DATA, CRC error, bad PID,
// overflow, short DATA, mid-packet reset and (optionally) timeout.
module tb_usb_rx_fsm;

  localparam int unsigned MaxData = 64;
  localparam int unsigned Timeout = 800;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_edge, byte_ready, eop, crc_ok;
  logic [7:0] rx_byte;
  logic       crc_clear, crc_enable, store_rx_data, rx_data_ready, rx_error, rcving;
  logic [7:0] rx_data;
  logic [1:0] rx_packet;
  logic [6:0] rx_data_size;

  int errors = 0;
  int checks = 0;

  // Monitor-owned counters; the stimulus only reads them.
  int       store_n = 0;
  int       ready_n = 0;
  int       crc_en_n = 0;
  logic [7:0] store_log [0:511];

  always #5 clk = ~clk;

  usb_rx_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .d_edge       (d_edge),
    .byte_ready   (byte_ready),
    .rx_byte      (rx_byte),
    .eop          (eop),
    .crc_ok       (crc_ok),
    .crc_clear    (crc_clear),
    .crc_enable   (crc_enable),
    .store_rx_data(store_rx_data),
    .rx_data      (rx_data),
    .rx_packet    (rx_packet),
    .rx_data_size (rx_data_size),
    .rx_data_ready(rx_data_ready),
    .rx_error     (rx_error),
    .rcving       (rcving)
  );

  always @(posedge clk) begin
    if (store_rx_data) begin
      store_log[store_n[8:0]] <= rx_data;
      store_n <= store_n + 1;
    end
    if (rx_data_ready) ready_n <= ready_n + 1;
    if (crc_enable) crc_en_n <= crc_en_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pkt();
    d_edge = 1'b1;
    cyc(1);
    d_edge = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_ready = 1'b1;
    rx_byte    = b;
    cyc(1);
    byte_ready = 1'b0;
    cyc(1);
  endtask

  task automatic end_pkt(input logic ok);
    eop    = 1'b1;
    crc_ok = ok;
    cyc(1);
    eop    = 1'b0;
    crc_ok = 1'b0;
    cyc(3);
  endtask

  function automatic logic [31:0] all_outs();
    return {8'd0, crc_clear, crc_enable, store_rx_data, rx_data, rx_packet,
            rx_data_size, rx_data_ready, rx_error, rcving};
  endfunction

  int s_base, r_base, c_base;

  initial begin
    rst = 1'b1; d_edge = 1'b0; byte_ready = 1'b0; eop = 1'b0; crc_ok = 1'b0;
    rx_byte = 8'h00;
    cyc(2);
    check("reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    cyc(1);

    // 1: ACK handshake
    s_base = store_n; r_base = ready_n;
    start_pkt();
    check("ack_crc_clear", {31'd0, crc_clear}, 32'd1);
    check("ack_rcving", {31'd0, rcving}, 32'd1);
    send(8'h80); send(8'hB4);
    end_pkt(1'b0);
    check("ack_packet", {30'd0, rx_packet}, 32'd2);
    check("ack_ready_pulses", ready_n - r_base, 32'd1);
    check("ack_error", {31'd0, rx_error}, 32'd0);
    check("ack_no_store", store_n - s_base, 32'd0);
    check("ack_rcving_done", {31'd0, rcving}, 32'd0);

    // 2: good DATA packet, three payload bytes
    s_base = store_n; r_base = ready_n; c_base = crc_en_n;
    start_pkt();
    send(8'h80); send(8'hC3);
    send(8'h11); send(8'h22); send(8'h33); send(8'hCA); send(8'hFE);
    end_pkt(1'b1);
    check("data_store_count", store_n - s_base, 32'd3);
    check("data_byte0", {24'd0, store_log[s_base]}, 32'h11);
    check("data_byte1", {24'd0, store_log[s_base + 1]}, 32'h22);
    check("data_byte2", {24'd0, store_log[s_base + 2]}, 32'h33);
    check("data_size", {25'd0, rx_data_size}, 32'd3);
    check("data_packet", {30'd0, rx_packet}, 32'd1);
    check("data_ready_pulses", ready_n - r_base, 32'd1);
    check("data_crc_enables", crc_en_n - c_base, 32'd5);
    check("data_error", {31'd0, rx_error}, 32'd0);

    // 3: same packet, CRC bad
    r_base = ready_n;
    start_pkt();
    send(8'h80); send(8'hC3);
    send(8'h11); send(8'h22); send(8'h33); send(8'hCA); send(8'hFE);
    end_pkt(1'b0);
    check("crcbad_error", {31'd0, rx_error}, 32'd1);
    check("crcbad_no_ready", ready_n - r_base, 32'd0);
    check("crcbad_packet", {30'd0, rx_packet}, 32'd0);
    check("crcbad_rcving", {31'd0, rcving}, 32'd0);

    // 4: bad PID, then ignored byte, eop, and a fresh d_edge
    s_base = store_n;
    start_pkt();
    check("badpid_error_cleared", {31'd0, rx_error}, 32'd0);
    send(8'h80); send(8'hC4);
    check("badpid_error", {31'd0, rx_error}, 32'd1);
    check("badpid_rcving", {31'd0, rcving}, 32'd1);
    start_pkt();  // ignored in ERR
    send(8'h55);
    check("badpid_still_err", {31'd0, rx_error, rcving}, 32'd3);
    end_pkt(1'b0);
    check("badpid_idle", {31'd0, rcving}, 32'd0);
    check("badpid_sticky", {31'd0, rx_error}, 32'd1);
    check("badpid_no_store", store_n - s_base, 32'd0);
    start_pkt();
    check("badpid_cleared", {31'd0, rx_error}, 32'd0);
    end_pkt(1'b0);  // eop while expecting SYNC
    check("sync_eop_error", {31'd0, rx_error, rcving}, 32'd2);

    // NAK handshake, then a handshake followed by a stray byte
    start_pkt();
    send(8'h80); send(8'hA5);
    end_pkt(1'b0);
    check("nak_packet", {30'd0, rx_packet}, 32'd3);
    start_pkt();
    send(8'h80); send(8'hB4); send(8'h00);
    check("ack_extra_byte", {31'd0, rx_error}, 32'd1);
    end_pkt(1'b0);

    // Short DATA: eop after one byte
    r_base = ready_n;
    start_pkt();
    send(8'h80); send(8'hC3); send(8'h11);
    end_pkt(1'b1);
    check("short_error", {31'd0, rx_error, rcving}, 32'd2);
    check("short_no_ready", ready_n - r_base, 32'd0);

    // 5: overflow, MaxData+1 payload + 2 CRC bytes
    s_base = store_n;
    start_pkt();
    send(8'h80); send(8'hC3);
    for (int i = 0; i < MaxData + 3; i++) begin
      if (i == MaxData + 2) check("ovf_no_early_error", {31'd0, rx_error}, 32'd0);
      send(8'(i));
    end
    check("ovf_error", {31'd0, rx_error, rcving}, 32'd3);
    check("ovf_store_count", store_n - s_base, MaxData);
    check("ovf_first", {24'd0, store_log[s_base]}, 32'd0);
    check("ovf_last", {24'd0, store_log[s_base + MaxData - 1]}, MaxData - 1);
    end_pkt(1'b0);
    check("ovf_idle", {31'd0, rcving}, 32'd0);

    // Reset in the middle of a DATA packet
    start_pkt();
    send(8'h80); send(8'hC3);
    send(8'h11); send(8'h22);
    byte_ready = 1'b1; rx_byte = 8'h33;
    cyc(1);
    byte_ready = 1'b0;
    check("pre_reset_store", {31'd0, store_rx_data}, 32'd1);
    s_base = store_n;
    rst = 1'b1;
    #1;
    check("midreset_outputs", all_outs(), 32'd0);
    cyc(2);
    rst = 1'b0;
    send(8'h44); send(8'h55); send(8'h66);
    cyc(2);
    check("midreset_no_store", store_n - s_base, 32'd0);
    check("midreset_idle", all_outs(), 32'd0);

`ifdef RX_TIMEOUT_EN
    // 6: timeout after SYNC
    start_pkt();
    send(8'h80);
    cyc(Timeout + 5);
    check("timeout_state", {31'd0, rx_error, rcving}, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_fsm.md
Name: usb_rx_fsm

Overview:
- Packet-level receive controller for the USB full-speed endpoint; the counterpart of the transmit controller.
- Consumes decoded, destuffed bytes from the RX shift register, checks SYNC and PID, and streams DATA payload bytes into the RX data buffer. CRC16 bytes are withheld from the buffer.
- Reports packet type, payload size, completion and error to the protocol layer.
- Uses the same PID/packet-code map as the TX path: 01 DATA, 10 ACK, 11 NAK.

Parameters:
MAX_DATA, 64, maximum payload bytes accepted, excluding PID and CRC.
TIMEOUT_CYCLES, 800, clock cycles allowed between byte strobes (used only with RX_TIMEOUT_EN).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
d_edge  input  1  bus activity detected (start of packet)
byte_ready  input  1  one-cycle strobe: rx_byte holds a complete received byte
rx_byte  input  8  received byte
eop  input  1  one-cycle strobe: end-of-packet detected on bus
crc_ok  input  1  CRC16 residue check passes (valid in the cycle eop is seen)
crc_clear  output  1  one-cycle pulse clearing the CRC16 checker
crc_enable  output  1  CRC16 checker accumulates the current byte
store_rx_data  output  1  one-cycle write strobe into the RX data buffer
rx_data  output  8  payload byte to the buffer
rx_packet  output  2  00 none, 01 DATA, 10 ACK, 11 NAK
rx_data_size  output  7  payload byte count of the last good DATA packet
rx_data_ready  output  1  one-cycle pulse: good packet complete
rx_error  output  1  malformed packet flag (sticky)
rcving  output  1  packet reception in progress

Behaviour:
- Reset: state IDLE; all outputs 0; hold registers and byte counter cleared. Reset mid-packet aborts the packet; nothing further is stored.
- All outputs are registered.
- States: IDLE, RCV_SYNC, RCV_PID, WAIT_EOP, RCV_DATA, DONE, ERR.
- IDLE: on d_edge, go to RCV_SYNC; pulse crc_clear; set rcving=1; clear rx_error; set rx_packet=00.
- RCV_SYNC:
  - byte_ready with rx_byte==8'h80 goes to RCV_PID.
  - Any other byte, or eop, goes to ERR.
- RCV_PID, on byte_ready:
  - 8'hC3 goes to RCV_DATA.
  - 8'hB4 (ACK) or 8'hA5 (NAK) goes to WAIT_EOP; the type is latched internally.
  - Any other value, including upper nibble != ~lower nibble, goes to ERR.
  - eop goes to ERR.
- WAIT_EOP:
  - eop goes to DONE.
  - byte_ready goes to ERR (extra bytes after a handshake PID).
- RCV_DATA:
  - crc_enable=1 in the cycle after each byte_ready.
  - Two-byte hold pipeline plus 8-bit counter cnt. On each byte_ready: when cnt>=2, the oldest held byte goes to rx_data with store_rx_data pulsed one cycle later; the new byte enters the pipeline; cnt increments.
  - Overflow: cnt reaching MAX_DATA+3 goes to ERR.
  - eop with cnt>=2 and crc_ok: rx_data_size = cnt-2 (truncated to 7 bits), go to DONE.
  - eop with cnt<2 or !crc_ok goes to ERR. Bytes already stored stay in the buffer; the protocol layer discards them on rx_error.
- Simultaneous byte_ready and eop in any receiving state goes to ERR.
- DONE: rx_packet takes the decoded type; pulse rx_data_ready one cycle; rcving=0; go to IDLE. rx_packet and rx_data_size hold until the next d_edge.
- ERR:
  - rx_error=1; rcving stays 1 and rx_packet=00.
  - Wait for eop, then go to IDLE with rcving=0; rx_error stays set.
  - d_edge while in ERR is ignored.
- d_edge outside IDLE is ignored.

Optional Feature:
RX_TIMEOUT_EN:
- When defined, a 16-bit idle counter runs in RCV_SYNC, RCV_PID, WAIT_EOP and RCV_DATA. It reloads on byte_ready.
- When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE directly: rx_error=1, rcving=0, no eop required.
- When undefined, the counter logic is absent and the FSM waits indefinitely for byte_ready or eop.

Test Plan:
1. d_edge; bytes 80, B4; eop -> rx_packet=10, rx_data_ready pulse 1 cycle, rx_error=0, no store_rx_data.
2. d_edge; bytes 80, C3, 11, 22, 33, CA, FE; eop with crc_ok=1 -> store_rx_data exactly 3 times with data 11, 22, 33; rx_data_size=3; rx_packet=01; rx_data_ready pulse.
3. Same as 2 with crc_ok=0 at eop -> rx_error=1, rx_data_ready never asserted, rx_packet=00, FSM back in IDLE.
4. d_edge; bytes 80, C4 (bad PID) -> ERR; subsequent byte_ready ignored; eop -> IDLE; next d_edge clears rx_error.
5. DATA packet with MAX_DATA+1 payload bytes + 2 CRC -> rx_error=1 at the overflow byte; store_rx_data count = MAX_DATA.
6. RX_TIMEOUT_EN defined: d_edge; byte 80; then TIMEOUT_CYCLES idle -> rx_error=1, rcving=0, IDLE. Also assert rst mid-RCV_DATA -> all outputs 0 immediately.
